// File: rtl/q32_comparator.sv
// q32_comparator: registered, pipelined signed "less-than-or-equal" compare
// for two's-complement fixed-point operands (Q32.32 by default). Used as the
// node-decision primitive of the decision-tree engine.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   en           operands valid; sampled on every rising edge
//   feature      signed operand, INT_W+FRAC_W bits
//   threshold    signed operand, INT_W+FRAC_W bits
//   go_left      registered result: feature <= threshold (signed)
//   compare_done registered strobe, one pulse per accepted operand pair,
//                LATENCY cycles after en was sampled
module q32_comparator #(
  parameter int unsigned INT_W   = 32,
  parameter int unsigned FRAC_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [INT_W+FRAC_W-1:0]   feature,
  input  logic [INT_W+FRAC_W-1:0]   threshold,
  output logic                      go_left,
  output logic                      compare_done
);

  localparam int unsigned W = INT_W + FRAC_W;

  generate
    if (LATENCY == 2) begin : g_lat2
      // Stage 1 splits the wide compare into an integer-part signed compare
      // and a fraction-part unsigned compare to shorten the critical path.
      logic int_lt;
      logic int_eq;
      logic frac_le;
      logic v1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          int_lt  <= 1'b0;
          int_eq  <= 1'b0;
          frac_le <= 1'b0;
          v1      <= 1'b0;
        end else begin
          v1 <= en;
          if (en) begin
            int_lt  <= $signed(feature[W-1:FRAC_W]) < $signed(threshold[W-1:FRAC_W]);
            int_eq  <= feature[W-1:FRAC_W] == threshold[W-1:FRAC_W];
            frac_le <= feature[FRAC_W-1:0] <= threshold[FRAC_W-1:0];
          end
        end
      end

      // Stage 2 combines the partial flags; go_left holds between results.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          go_left      <= 1'b0;
          compare_done <= 1'b0;
        end else begin
          compare_done <= v1;
          if (v1) begin
            go_left <= int_lt | (int_eq & frac_le);
          end
        end
      end
    end else if (LATENCY == 1) begin : g_lat1
      // Single stage: full-width signed compare straight into the output flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          go_left      <= 1'b0;
          compare_done <= 1'b0;
        end else begin
          compare_done <= en;
          if (en) begin
            go_left <= $signed(feature) <= $signed(threshold);
          end
        end
      end
    end else begin : g_bad_latency
      $error("q32_comparator: LATENCY must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_q32_comparator.sv
// tb_q32_comparator: self-checking bench for q32_comparator (LATENCY=2).
// Directed operand pairs push a hand-computed expected go_left into a queue;
// an independent monitor pops and compares on every compare_done pulse.
module tb_q32_comparator;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] feature;
  logic [W-1:0] threshold;
  logic         go_left;
  logic         compare_done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit exp_q[$];

  q32_comparator #(.INT_W(32), .FRAC_W(32), .LATENCY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .feature      (feature),
    .threshold    (threshold),
    .go_left      (go_left),
    .compare_done (compare_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && compare_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(compare_done), 64'(0));
      end else begin
        check("go_left", 64'(go_left), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [W-1:0] f, input logic [W-1:0] t, input bit exp);
    @(negedge clk);
    en        = 1'b1;
    feature   = f;
    threshold = t;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      en = 1'b0;
      cyc++;
    end
    #1;
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int d0;
    rst_n     = 1'b0;
    en        = 1'b0;
    feature   = '0;
    threshold = '0;
    #12;
    check("rst_go_left", 64'(go_left), 64'(0));
    check("rst_done", 64'(compare_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled after reset: operands change, outputs stay 0.
    @(negedge clk);
    feature   = 64'h00000002_00000000;
    threshold = 64'h00000001_00000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dis_done", 64'(compare_done), 64'(0));
      check("dis_go_left", 64'(go_left), 64'(0));
    end

    // Basic magnitudes.
    issue(64'h00000001_80000000, 64'h00000002_00000000, 1'b1);  // 1.5 <= 2.0
    issue(64'h00000002_80000000, 64'h00000002_00000000, 1'b0);  // 2.5 <= 2.0
    issue(64'h00000002_00000000, 64'h00000002_00000000, 1'b1);  // equal
    // Signs.
    issue(64'hFFFFFFFF_00000000, 64'h00000001_00000000, 1'b1);  // -1 <= 1
    issue(64'h00000001_00000000, 64'hFFFFFFFF_00000000, 1'b0);  // 1 <= -1
    issue(64'h80000000_00000000, 64'h80000000_00000000, 1'b1);  // min == min
    issue(64'h80000001_00000000, 64'h80000000_00000000, 1'b0);
    issue(64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 1'b1);  // min <= max
    issue(64'h7FFFFFFF_FFFFFFFF, 64'h80000000_00000000, 1'b0);
    // Fraction precision and zero.
    issue(64'h00000001_00000000, 64'h00000001_00000001, 1'b1);
    issue(64'h00000001_00000001, 64'h00000001_00000000, 1'b0);
    issue(64'h7FFFFFFF_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFE, 1'b0);
    issue(64'h00000000_00000000, 64'h00000000_00000000, 1'b1);
    issue(64'h00000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b0);  // 0 <= -2^-32
    issue(64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000000, 1'b1);
    issue(64'hFFFFFFFF_80000000, 64'hFFFFFFFF_7FFFFFFF, 1'b0);  // negative, frac 1 LSB
    drain();

    // Streaming: 4 back-to-back with alternating result.
    idle(2);
    d0 = done_cnt;
    issue(64'h00000001_00000000, 64'h00000002_00000000, 1'b1);
    issue(64'h00000002_00000000, 64'h00000001_00000000, 1'b0);
    issue(64'h00000001_00000000, 64'h00000002_00000000, 1'b1);
    issue(64'h00000002_00000000, 64'h00000001_00000000, 1'b0);
    drain();
    idle(3);
    check("stream_done_count", 64'(done_cnt - d0), 64'(4));

    // Hold: go_left keeps 1 while en=0 even if operands would give 0.
    issue(64'h00000001_00000000, 64'h00000002_00000000, 1'b1);
    drain();
    feature   = 64'h00000002_00000000;
    threshold = 64'h00000001_00000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_done", 64'(compare_done), 64'(0));
      check("hold_go_left", 64'(go_left), 64'(1));
    end

    // Reset before compare_done: in-flight result discarded.
    issue(64'h00000005_00000000, 64'h00000003_00000000, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_go_left", 64'(go_left), 64'(0));
    check("rst_mid_done", 64'(compare_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 64'(compare_done), 64'(0));
      check("post_rst_go_left", 64'(go_left), 64'(0));
    end

    // Reset while compare_done is high: asynchronous clear.
    issue(64'h00000003_00000000, 64'h00000005_00000000, 1'b1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_done_high", 64'(compare_done), 64'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_go_left", 64'(go_left), 64'(0));
    check("async_done", 64'(compare_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_async_done", 64'(compare_done), 64'(0));
      check("post_async_go_left", 64'(go_left), 64'(0));
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
